// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port among N_REQ requesters, each behind a small FIFO.
// Round-robin drain of one entry per cycle into registered port outputs, plus a per-register busy mask.
module regfile_write_arbiter #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [2*N_REQ-1:0]    req_part,
  input  logic [3*N_REQ-1:0]    req_id,
  input  logic [16*N_REQ-1:0]   req_data,
  output logic                  we,
  output logic [1:0]            write_part,
  output logic [2:0]            write_id,
  output logic [15:0]           write_data,
  output logic [7:0]            busy,
  output logic                  idle
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [1:0]    part_q [N_REQ][DEPTH];
  logic [2:0]    id_q   [N_REQ][DEPTH];
  logic [15:0]   data_q [N_REQ][DEPTH];
  logic [AW-1:0] rd_ptr_q [N_REQ];
  logic [AW-1:0] wr_ptr_q [N_REQ];
  logic [CW-1:0] count_q  [N_REQ];
  logic [PW-1:0] rr_q, rr_d;

  logic [N_REQ-1:0] push, pop;
  logic             grant_valid;
  logic [PW-1:0]    grant_idx;

  logic          we_q;
  logic [1:0]    write_part_q;
  logic [2:0]    write_id_q;
  logic [15:0]   write_data_q;

  // First non-empty FIFO searching upward from the round-robin pointer.
  always_comb begin
    logic [PW-1:0] cand;
    cand        = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = PW'((32'(rr_q) + k) % N_REQ);
      if (!grant_valid && (count_q[cand] != '0)) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
    rr_d = rr_q;
    if (grant_valid) begin
      rr_d = (grant_idx == PW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Ready is taken from registered count only, so a full FIFO never accepts on its pop cycle.
  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      req_ready[i] = (count_q[i] != CW'(DEPTH));
      push[i]      = req_valid[i] && req_ready[i];
      pop[i]       = grant_valid && (grant_idx == PW'(i));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_q <= '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
    end else begin
      rr_q <= rr_d;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
        count_q[i] <= count_q[i] + CW'(push[i]) - CW'(pop[i]);
      end
    end
  end

  // Entry storage needs no reset: validity is tracked by the pointers and counts.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (push[i]) begin
        part_q[i][wr_ptr_q[i]] <= req_part[2*i +: 2];
        id_q[i][wr_ptr_q[i]]   <= req_id[3*i +: 3];
        data_q[i][wr_ptr_q[i]] <= req_data[16*i +: 16];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q         <= 1'b0;
      write_part_q <= 2'b00;
      write_id_q   <= 3'd0;
      write_data_q <= 16'd0;
    end else if (grant_valid) begin
      we_q         <= (part_q[grant_idx][rd_ptr_q[grant_idx]] != 2'b00);
      write_part_q <= part_q[grant_idx][rd_ptr_q[grant_idx]];
      write_id_q   <= id_q[grant_idx][rd_ptr_q[grant_idx]];
      write_data_q <= data_q[grant_idx][rd_ptr_q[grant_idx]];
    end else begin
      we_q <= 1'b0;
    end
  end

  always_comb begin
    logic [AW-1:0] off;
    off  = '0;
    busy = '0;
    idle = !we_q;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (count_q[i] != '0) idle = 1'b0;
      for (int unsigned j = 0; j < DEPTH; j++) begin
        off = AW'(j) - rd_ptr_q[i];
        if (({1'b0, off} < count_q[i]) && (part_q[i][j] != 2'b00)) busy[id_q[i][j]] = 1'b1;
      end
    end
    if (we_q) busy[write_id_q] = 1'b1;
  end

  assign we         = we_q;
  assign write_part = write_part_q;
  assign write_id   = write_id_q;
  assign write_data = write_data_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: reset, latency, round-robin, backpressure,
// no-op/byte parts and same-register ordering.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [5:0]  req_part;
  logic [8:0]  req_id;
  logic [47:0] req_data;
  logic        we;
  logic [1:0]  write_part;
  logic [2:0]  write_id;
  logic [15:0] write_data;
  logic [7:0]  busy;
  logic        idle;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_write_arbiter #(.N_REQ(3), .DEPTH(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_part   (req_part),
    .req_id     (req_id),
    .req_data   (req_data),
    .we         (we),
    .write_part (write_part),
    .write_id   (write_id),
    .write_data (write_data),
    .busy       (busy),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic [1:0] p, input logic [2:0] id,
                       input logic [15:0] d);
    req_valid[i]       = v;
    req_part[2*i +: 2] = p;
    req_id[3*i +: 3]   = id;
    req_data[16*i +: 16] = d;
  endtask

  task automatic clear_all();
    req_valid = '0;
    req_part  = '0;
    req_id    = '0;
    req_data  = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_all();
    #2;
    n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", we); end
    n_checks++; if (write_part !== 2'b00) begin
      n_fail++; $display("FAIL reset_part: got %b want 00", write_part); end
    n_checks++; if (write_id !== 3'd0) begin
      n_fail++; $display("FAIL reset_id: got %0d want 0", write_id); end
    n_checks++; if (write_data !== 16'h0000) begin
      n_fail++; $display("FAIL reset_data: got %h want 0000", write_data); end
    n_checks++; if (busy !== 8'h00) begin n_fail++; $display("FAIL reset_busy: got %h want 00", busy); end
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b want 1", idle); end
    tick();
    tick();
    reset = 1'b1;
    tick();
    n_checks++; if (req_ready !== 3'b111) begin
      n_fail++; $display("FAIL reset_ready: got %b want 111", req_ready); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) drive(i, 1'b1, 2'b11, 3'(i), 16'(32'h1100 + i));
    tick();
    tick();
    clear_all();
    n_checks++; if (we !== 1'b1 || write_id !== 3'd0) begin
      n_fail++; $display("FAIL mid_pre: got we=%b id=%0d want we=1 id=0", we, write_id); end
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL mid_we: got %b want 0", we); end
    n_checks++; if (busy !== 8'h00) begin n_fail++; $display("FAIL mid_busy: got %h want 00", busy); end
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL mid_idle: got %b want 1", idle); end
    tick();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++; if (we !== 1'b0) begin
        n_fail++; $display("FAIL mid_discard: cycle %0d got we=%b want 0", k, we); end
    end
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL mid_idle2: got %b want 1", idle); end
  endtask

  task automatic test_single_latency();
    drive(0, 1'b1, 2'b11, 3'd3, 16'h1234);
    tick();
    clear_all();
    n_checks++; if (we !== 1'b0 || busy !== 8'h08) begin
      n_fail++; $display("FAIL lat_queued: got we=%b busy=%h want we=0 busy=08", we, busy); end
    tick();
    n_checks++; if ({we, write_part, write_id, write_data} !== {1'b1, 2'b11, 3'd3, 16'h1234}) begin
      n_fail++; $display("FAIL lat_port: got we=%b part=%b id=%0d data=%h want 1 11 3 1234",
                         we, write_part, write_id, write_data); end
    n_checks++; if (busy !== 8'h08) begin n_fail++; $display("FAIL lat_busy: got %h want 08", busy); end
    tick();
    n_checks++; if (we !== 1'b0 || busy !== 8'h00 || idle !== 1'b1) begin
      n_fail++; $display("FAIL lat_done: got we=%b busy=%h idle=%b want 0 00 1", we, busy, idle); end
    // Single write from requester 2 brings the pointer back to 0.
    drive(2, 1'b1, 2'b11, 3'd6, 16'hBEEF);
    tick();
    clear_all();
    tick();
    n_checks++; if (we !== 1'b1 || write_id !== 3'd6 || write_data !== 16'hBEEF) begin
      n_fail++; $display("FAIL lat_req2: got we=%b id=%0d data=%h want 1 6 beef",
                         we, write_id, write_data); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [15:0] exp_data;
    for (int i = 0; i < 3; i++) drive(i, 1'b1, 2'b11, 3'(i), 16'(32'hA000 + 16 * i));
    tick();
    for (int i = 0; i < 3; i++) drive(i, 1'b1, 2'b11, 3'(i), 16'(32'hA001 + 16 * i));
    tick();
    clear_all();
    for (int k = 0; k < 6; k++) begin
      exp_data = 16'(32'hA000 + 16 * (k % 3) + (k / 3));
      n_checks++; if (we !== 1'b1 || write_id !== 3'(k % 3) || write_data !== exp_data) begin
        n_fail++; $display("FAIL rr_grant%0d: got we=%b id=%0d data=%h want 1 %0d %h",
                           k, we, write_id, write_data, k % 3, exp_data); end
      tick();
    end
    n_checks++; if (we !== 1'b0 || idle !== 1'b1) begin
      n_fail++; $display("FAIL rr_idle: got we=%b idle=%b want 0 1", we, idle); end
  endtask

  task automatic test_backpressure();
    drive(0, 1'b1, 2'b11, 3'd0, 16'h0B00);
    drive(1, 1'b1, 2'b11, 3'd1, 16'hB001);
    drive(2, 1'b1, 2'b11, 3'd2, 16'h2B00);
    tick();
    drive(0, 1'b0, 2'b00, 3'd0, 16'h0000);
    drive(2, 1'b0, 2'b00, 3'd0, 16'h0000);
    drive(1, 1'b1, 2'b11, 3'd1, 16'hB002);
    tick();
    n_checks++; if (req_ready[1] !== 1'b0) begin
      n_fail++; $display("FAIL bp_full: got ready1=%b want 0", req_ready[1]); end
    n_checks++; if (we !== 1'b1 || write_data !== 16'h0B00) begin
      n_fail++; $display("FAIL bp_g0: got we=%b data=%h want 1 0b00", we, write_data); end
    drive(1, 1'b1, 2'b11, 3'd1, 16'hB003);
    tick();
    n_checks++; if (write_data !== 16'hB001) begin
      n_fail++; $display("FAIL bp_g1: got %h want b001", write_data); end
    n_checks++; if (req_ready[1] !== 1'b1) begin
      n_fail++; $display("FAIL bp_popcycle: got ready1=%b want 1", req_ready[1]); end
    tick();
    clear_all();
    n_checks++; if (write_data !== 16'h2B00 || req_ready[1] !== 1'b0) begin
      n_fail++; $display("FAIL bp_g2: got data=%h ready1=%b want 2b00 0", write_data, req_ready[1]); end
    tick();
    n_checks++; if (we !== 1'b1 || write_data !== 16'hB002) begin
      n_fail++; $display("FAIL bp_b2: got we=%b data=%h want 1 b002", we, write_data); end
    tick();
    n_checks++; if (we !== 1'b1 || write_data !== 16'hB003) begin
      n_fail++; $display("FAIL bp_b3: got we=%b data=%h want 1 b003", we, write_data); end
    tick();
    n_checks++; if (we !== 1'b0 || idle !== 1'b1) begin
      n_fail++; $display("FAIL bp_idle: got we=%b idle=%b want 0 1", we, idle); end
  endtask

  task automatic test_noop_parts();
    drive(0, 1'b1, 2'b00, 3'd5, 16'h5A5A);
    tick();
    n_checks++; if (busy !== 8'h00) begin
      n_fail++; $display("FAIL noop_busy: got %h want 00", busy); end
    drive(0, 1'b1, 2'b01, 3'd5, 16'h00AB);
    tick();
    n_checks++; if (we !== 1'b0 || write_id !== 3'd5 || write_data !== 16'h5A5A) begin
      n_fail++; $display("FAIL noop_port: got we=%b id=%0d data=%h want 0 5 5a5a",
                         we, write_id, write_data); end
    n_checks++; if (busy !== 8'h20) begin
      n_fail++; $display("FAIL noop_busy2: got %h want 20", busy); end
    drive(0, 1'b1, 2'b10, 3'd5, 16'hCD00);
    tick();
    clear_all();
    n_checks++; if ({we, write_part, write_data} !== {1'b1, 2'b01, 16'h00AB}) begin
      n_fail++; $display("FAIL lo_byte: got we=%b part=%b data=%h want 1 01 00ab",
                         we, write_part, write_data); end
    tick();
    n_checks++; if ({we, write_part, write_data} !== {1'b1, 2'b10, 16'hCD00}) begin
      n_fail++; $display("FAIL hi_byte: got we=%b part=%b data=%h want 1 10 cd00",
                         we, write_part, write_data); end
    tick();
    n_checks++; if (we !== 1'b0 || busy !== 8'h00 || idle !== 1'b1) begin
      n_fail++; $display("FAIL parts_done: got we=%b busy=%h idle=%b want 0 00 1", we, busy, idle); end
  endtask

  task automatic test_same_register();
    drive(0, 1'b1, 2'b11, 3'd7, 16'h7000);
    drive(2, 1'b1, 2'b11, 3'd7, 16'h7002);
    tick();
    clear_all();
    n_checks++; if (we !== 1'b0 || busy !== 8'h80) begin
      n_fail++; $display("FAIL same_q: got we=%b busy=%h want 0 80", we, busy); end
    tick();
    n_checks++; if (we !== 1'b1 || write_data !== 16'h7002 || busy !== 8'h80) begin
      n_fail++; $display("FAIL same_first: got we=%b data=%h busy=%h want 1 7002 80",
                         we, write_data, busy); end
    tick();
    n_checks++; if (we !== 1'b1 || write_data !== 16'h7000 || busy !== 8'h80) begin
      n_fail++; $display("FAIL same_second: got we=%b data=%h busy=%h want 1 7000 80",
                         we, write_data, busy); end
    tick();
    n_checks++; if (we !== 1'b0 || busy !== 8'h00 || idle !== 1'b1) begin
      n_fail++; $display("FAIL same_done: got we=%b busy=%h idle=%b want 0 00 1", we, busy, idle); end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_single_latency();
    test_round_robin();
    test_backpressure();
    test_noop_parts();
    test_same_register();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
